lipsi_core_p: RTL

Parametrised accumulator processor core, the next generation of the team's 8-bit Lipsi CPU. It adds configurable data width and data-memory depth, a program-load port, a run/halt handshake, a data-memory clear sweep after reset, borrow-correct subtraction and an output-port instruction. It sits below the board wrapper (clock divider, seven-segment driver), which consumes `acc`, `out_data` and `halted`.

---
 rtl/lipsi_core_p.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/lipsi_core_p.sv
// Parametrised Lipsi accumulator core: 256-byte program store with a load port,
// a data memory swept to zero after reset, and a run/halt handshake.
module lipsi_core_p #(
    parameter int DATA_W  = 8,
    parameter int DMEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              prog_we,
    input  logic [7:0]        prog_addr,
    input  logic [7:0]        prog_data,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic [7:0]        pc_o,
    output logic              busy,
    output logic              halted,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_EXEC, S_IMM, S_BR, S_HALT} state_t;

    localparam int DEPTH = 1 << DMEM_AW;

    logic [7:0]        pmem [256];
    logic [DATA_W-1:0] dmem [DEPTH];

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
    logic              carry_q, carry_d, out_valid_q, out_valid_d;
    logic [7:0]        pc_q, pc_d;
    logic [DMEM_AW-1:0] clr_idx_q, clr_idx_d;

    logic [7:0]         instr, operand, pc_inc1, pc_inc2;
    logic [DMEM_AW-1:0] dir_addr, ind_addr, wr_addr;
    logic [DATA_W-1:0]  dir_data, ind_data, wr_data, alu_x, alu_res, shf_res;
    logic [DATA_W:0]    sum_ext;
    logic [2:0]         alu_op;
    logic               alu_c, shf_c, wr_en, br_taken;

    // The opcode stays addressed by pc during IMM/BR, so it need not be latched.
    assign instr    = pmem[pc_q];
    assign pc_inc1  = pc_q + 8'd1;
    assign pc_inc2  = pc_q + 8'd2;
    assign operand  = pmem[pc_inc1];
    assign dir_addr = DMEM_AW'(instr[3:0]);
    assign dir_data = dmem[dir_addr];
    assign ind_addr = dir_data[DMEM_AW-1:0];
    assign ind_data = dmem[ind_addr];

    assign alu_op = (state_q == S_IMM) ? instr[2:0] : instr[6:4];
    assign alu_x  = (state_q == S_IMM) ? DATA_W'(operand) : dir_data;

    always_comb begin
        sum_ext = '0;
        alu_res = acc_q;
        alu_c   = carry_q;
        case (alu_op)
            3'd0: sum_ext = {1'b0, acc_q} + {1'b0, alu_x};
            3'd1: sum_ext = {1'b0, acc_q} - {1'b0, alu_x};
            3'd2: sum_ext = {1'b0, acc_q} + {1'b0, alu_x} + (DATA_W+1)'(carry_q);
            3'd3: sum_ext = {1'b0, acc_q} - {1'b0, alu_x} - (DATA_W+1)'(carry_q);
            3'd4: alu_res = acc_q & alu_x;
            3'd5: alu_res = acc_q | alu_x;
            3'd6: alu_res = acc_q ^ alu_x;
            default: alu_res = alu_x;
        endcase
        // The extra top bit of the widened result is carry for add, borrow for sub.
        if (alu_op[2] == 1'b0) begin
            alu_res = sum_ext[DATA_W-1:0];
            alu_c   = sum_ext[DATA_W];
        end
    end

    always_comb begin
        shf_res = acc_q;
        shf_c   = carry_q;
        if (instr[2]) begin
            case (instr[1:0])
                2'd0: shf_res = {acc_q[DATA_W-2:0], acc_q[DATA_W-1]};
                2'd1: begin shf_res = {acc_q[DATA_W-2:0], carry_q}; shf_c = acc_q[DATA_W-1]; end
                2'd2: shf_res = {acc_q[DATA_W-2:0], 1'b0};
                default: begin shf_res = {acc_q[DATA_W-2:0], 1'b0}; shf_c = acc_q[DATA_W-1]; end
            endcase
        end else begin
            case (instr[1:0])
                2'd0: shf_res = {acc_q[0], acc_q[DATA_W-1:1]};
                2'd1: begin shf_res = {carry_q, acc_q[DATA_W-1:1]}; shf_c = acc_q[0]; end
                2'd2: shf_res = {1'b0, acc_q[DATA_W-1:1]};
                default: begin shf_res = {1'b0, acc_q[DATA_W-1:1]}; shf_c = acc_q[0]; end
            endcase
        end
    end

    always_comb begin
        case (instr[1:0])
            2'b00:   br_taken = 1'b1;
            2'b10:   br_taken = (acc_q == '0);
            2'b11:   br_taken = (acc_q != '0);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        pc_d        = pc_q;
        clr_idx_d   = clr_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = dir_addr;
        wr_data     = acc_q;
        case (state_q)
            S_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_idx_q;
                wr_data   = '0;
                clr_idx_d = clr_idx_q + DMEM_AW'(1);
                if (&clr_idx_q) state_d = S_IDLE;
            end
            S_IDLE, S_HALT: begin
                if (run) begin
                    pc_d    = 8'd0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d = pc_inc1;
                casez (instr[7:4])
                    4'b0???: begin acc_d = alu_res; carry_d = alu_c; end
                    4'b1000: wr_en = 1'b1;
                    4'b1001: begin
                        wr_en   = 1'b1;
                        wr_data = DATA_W'(pc_inc1);
                        pc_d    = acc_q[7:0];
                    end
                    4'b1010: acc_d = ind_data;
                    4'b1011: begin wr_en = 1'b1; wr_addr = ind_addr; end
                    4'b1100: begin pc_d = pc_q; state_d = S_IMM; end
                    4'b1101: begin pc_d = pc_q; state_d = S_BR; end
                    4'b1110: begin acc_d = shf_res; carry_d = shf_c; end
                    default: begin
                        if (instr[3:0] == 4'hF) begin
                            pc_d    = pc_q;
                            state_d = S_HALT;
                        end else if (instr[3:0] == 4'h0) begin
                            out_data_d  = acc_q;
                            out_valid_d = 1'b1;
                        end
                    end
                endcase
            end
            S_IMM: begin
                acc_d   = alu_res;
                carry_d = alu_c;
                pc_d    = pc_inc2;
                state_d = S_EXEC;
            end
            S_BR: begin
                pc_d    = br_taken ? operand : pc_inc2;
                state_d = S_EXEC;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            pc_q        <= 8'd0;
            clr_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            pc_q        <= pc_d;
            clr_idx_q   <= clr_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Memories carry no reset: program survives it, data is cleared by the sweep.
    always_ff @(posedge clk) begin
        if (wr_en) dmem[wr_addr] <= wr_data;
        if (prog_we && (state_q == S_IDLE || state_q == S_HALT)) pmem[prog_addr] <= prog_data;
    end

    assign acc       = acc_q;
    assign carry     = carry_q;
    assign pc_o      = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == S_HALT);
    assign busy      = (state_q == S_CLEAR) || (state_q == S_EXEC) ||
                       (state_q == S_IMM) || (state_q == S_BR);
endmodule
